// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad column scan, row sync, debounce, hold
// Revision 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] fil,
  output logic [3:0] col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [3:0]    cap_row_q, cap_row_d, cap_col_q, cap_col_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [3:0]    fil_q, fil_d, col_q, col_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;

  logic          dwell_end;
  logic          sample_one_hot;
  logic          row_present;
  logic [3:0]    col_rot;
  logic [CW-1:0] match_inc, rel_inc;

  assign dwell_end      = (dwell_q == DWELL_LAST);
  assign sample_one_hot = (sync2_q != 4'b0) && ((sync2_q & (sync2_q - 4'd1)) == 4'b0);
  assign row_present    = ((sync2_q & cap_row_q) != 4'b0);
  assign col_rot        = {col_out_q[2:0], col_out_q[3]};
  assign match_inc      = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + CW'(1);
  assign rel_inc        = (rel_cnt_q == CNT_MAX) ? rel_cnt_q : rel_cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      sync1_q     <= 4'b0;
      sync2_q     <= 4'b0;
      dwell_q     <= '0;
      col_out_q   <= 4'b0001;
      cap_row_q   <= 4'b0;
      cap_col_q   <= 4'b0;
      match_cnt_q <= '0;
      rel_cnt_q   <= '0;
      fil_q       <= 4'b0;
      col_q       <= 4'b0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dwell_q     <= dwell_d;
      col_out_q   <= col_out_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      match_cnt_q <= match_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      fil_q       <= fil_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dwell_end) begin
      case (state_q)
        ST_SCAN: begin
          if (sample_one_hot) state_d = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (sync2_q != cap_row_q)      state_d = ST_SCAN;
          else if (match_inc == CNT_MAX) state_d = ST_HELD;
        end
        ST_HELD: begin
          if (!row_present && rel_inc == CNT_MAX) state_d = ST_SCAN;
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    sync1_d     = row_in;
    sync2_d     = sync1_q;
    dwell_d     = dwell_end ? '0 : dwell_q + DW'(1);
    col_out_d   = col_out_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    match_cnt_d = match_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    fil_d       = fil_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (dwell_end) begin
      case (state_q)
        ST_SCAN: begin
          if (sample_one_hot) begin
            cap_row_d   = sync2_q;
            cap_col_d   = col_out_q;
            match_cnt_d = CW'(1);
          end else begin
            col_out_d = col_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (sync2_q == cap_row_q) begin
            match_cnt_d = match_inc;
            if (match_inc == CNT_MAX) begin
              fil_d       = cap_row_q;
              col_d       = cap_col_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_cnt_d   = '0;
            end
          end else begin
            match_cnt_d = '0;
            col_out_d   = col_rot;
          end
        end
        ST_HELD: begin
          // Only the accepted row matters; extra keys on the column are ignored
          if (row_present) begin
            rel_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_inc;
            if (rel_inc == CNT_MAX) begin
              key_held_d = 1'b0;
              rel_cnt_d  = '0;
              col_out_d  = col_rot;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    col_out   = col_out_q;
    fil       = fil_q;
    col       = col_q;
    key_valid = key_valid_q;
    key_held  = key_held_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed checks of keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3)
// Revision 1.0
// ============================================================================
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out, fil, col;
  logic       key_valid, key_held;

  logic       use_model;
  logic [3:0] key_row, key_col, raw_rows;

  int errors;
  int checks;
  int cyc;
  int kv_count;
  int guard;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .fil       (fil),
    .col       (col),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Keypad model: pressed key connects its column drive to its row
  assign row_in = use_model ? (((col_out & key_col) != 4'b0) ? key_row : 4'b0) : raw_rows;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) kv_count++;
  endtask

  task automatic wait_col1();
    guard = 0;
    while (!(col_out == 4'b0001 && (cyc % 4) == 0) && guard < 64) begin
      tick();
      guard++;
    end
    chk("wait_col1_timeout", (guard < 64) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    logic [3:0] exp_col;
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    kv_count  = 0;
    use_model = 1'b0;
    key_row   = 4'b0;
    key_col   = 4'b0;
    raw_rows  = 4'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #21;
    chk("rst_col_out", col_out, 4'b0001);
    chk("rst_fil", fil, 4'b0);
    chk("rst_col", col, 4'b0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_held", key_held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Idle scan: column advances every 4 cycles
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_col = 4'b0001 << ((cyc / 4) % 4);
      chk("idle_col_out", col_out, exp_col);
      chk("idle_key_valid", key_valid, 1'b0);
    end

    // Press row 0100 on column 0010
    use_model = 1'b1;
    key_row   = 4'b0100;
    key_col   = 4'b0010;
    guard = 0;
    while (!key_valid && guard < 100) begin
      tick();
      guard++;
    end
    chk("press_valid_cycle", cyc, 64);
    chk("press_key_valid", key_valid, 1'b1);
    chk("press_fil", fil, 4'b0100);
    chk("press_col", col, 4'b0010);
    chk("press_key_held", key_held, 1'b1);
    chk("press_col_out", col_out, 4'b0010);
    tick();
    chk("press_pulse_end", key_valid, 1'b0);
    while (cyc < 80) tick();
    chk("held_col_frozen", col_out, 4'b0010);
    chk("held_key_held", key_held, 1'b1);
    chk("held_one_pulse", kv_count, 1);

    // Release: three clear dwell ends drop key_held
    key_col = 4'b0;
    while (cyc < 91) tick();
    chk("rel_still_held", key_held, 1'b1);
    tick();
    chk("rel_key_held", key_held, 1'b0);
    chk("rel_col_out", col_out, 4'b0100);
    chk("rel_fil_kept", fil, 4'b0100);
    chk("rel_col_kept", col, 4'b0010);
    chk("rel_no_pulse", kv_count, 1);

    // Bounce: set for one dwell end, clear for the next
    use_model = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_col1();
      raw_rows = 4'b0001;
      repeat (4) tick();
      chk("bounce_col_frozen", col_out, 4'b0001);
      raw_rows = 4'b0000;
      repeat (4) tick();
      chk("bounce_col_resume", col_out, 4'b0010);
    end
    chk("bounce_no_pulse", kv_count, 1);
    chk("bounce_key_held", key_held, 1'b0);

    // Two rows at once are ignored
    wait_col1();
    raw_rows = 4'b0011;
    repeat (4) tick();
    chk("tworow_col_out", col_out, 4'b0010);
    raw_rows = 4'b0000;
    chk("tworow_no_pulse", kv_count, 1);

    // Reset in the middle of debounce (match count 2)
    wait_col1();
    raw_rows = 4'b1000;
    repeat (8) tick();
    chk("deb_col_frozen", col_out, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("midrst_col_out", col_out, 4'b0001);
    chk("midrst_fil", fil, 4'b0);
    chk("midrst_col", col, 4'b0);
    chk("midrst_key_valid", key_valid, 1'b0);
    chk("midrst_key_held", key_held, 1'b0);
    raw_rows = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    kv_count = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_col = 4'b0001 << ((cyc / 4) % 4);
      chk("postrst_col_out", col_out, exp_col);
      chk("postrst_key_held", key_held, 1'b0);
    end
    chk("postrst_no_pulse", kv_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
